cla8_pipe: RTL and testbench
============================

CLA8_PIPE -- requirements
Module: cla8_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width; legal values 8 and 16 only.
REQ-002 The clock and reset ports SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 sum  output  WIDTH  registered a+b+cin, modulo 2^WIDTH.
REQ-013 cout  output  1  registered carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow flag; present only under CLA8_PIPE_OVF_EN.

Function
REQ-015 Stage 1 SHALL register per-bit h=a^b, p=a|b and g=a&b, plus cin and valid bit s1_v, on every input accept.
REQ-016 Stage 2 SHALL compute carries from the stage-1 registers with a log2(WIDTH)-level parallel-prefix tree.
REQ-017 Each prefix node SHALL implement G=gh|(ph&gl) and P=ph&pl.
REQ-018 cin SHALL enter the tree as the generate term at position -1.
REQ-019 Bit carries SHALL be c0=cin, c(i+1)=prefix G over [i:-1], and sum_i SHALL equal h_i^c_i.
REQ-020 cout SHALL equal c(WIDTH).
REQ-021 Stage 2 results SHALL be registered into sum/cout with out_valid=1.
REQ-022 An input accept SHALL occur when in_valid&in_ready; an output handoff SHALL occur when out_valid&out_ready.
REQ-023 Stage-2 load: adv2 = s1_v & (~out_valid | out_ready).
REQ-024 in_ready SHALL equal ~rst & (~s1_v | adv2); the combinational out_ready->in_ready path is permitted.
REQ-025 Latency: a beat accepted in cycle N SHALL appear with out_valid=1 in cycle N+2 when there is no backpressure.
REQ-026 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-027 While out_valid & ~out_ready, sum, cout and ovf SHALL hold stable, and stage 1 SHALL hold if occupied.
REQ-028 With both stages full and stalled, in_ready SHALL be 0 and no beat SHALL be lost or duplicated.
REQ-029 On a simultaneous handoff and stage-2 load, out_valid SHALL stay 1 with the new result.
REQ-030 If out_valid is handed off with no stage-2 load, out_valid SHALL fall to 0 and sum/cout SHALL hold their last values.
REQ-031 Beats SHALL exit in acceptance order.

Reset
REQ-032 While rst=1 at a clock edge: s1_v=0, out_valid=0, sum=0, cout=0, ovf=0, and stage-1 vectors=0.
REQ-033 in_ready SHALL be 0 during any cycle with rst=1 and 1 in the first cycle after rst falls.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight beats with no output handoff.

Configuration
REQ-035 Macro CLA8_PIPE_OVF_EN defined: port ovf SHALL exist and be registered alongside sum.
REQ-036 With the macro defined, ovf SHALL equal c(WIDTH)^c(WIDTH-1) and follow the same hold and reset rules as cout.
REQ-037 Macro undefined: port ovf and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-038 Carry ripple: reset, then a=8'hFF, b=8'h01, cin=0 accepted in cycle N -> cycle N+2 sum=8'h00, cout=1 (ovf=0 if enabled).
REQ-039 Streaming: 256 back-to-back random beats with out_ready=1 -> each result matches a+b+cin, one result per cycle, in order.
REQ-040 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts, outputs hold, and all beats drain in order after release.
REQ-041 Overflow (macro defined): a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
REQ-042 Mid-op reset: rst pulsed for 1 cycle with both stages full -> out_valid=0 next cycle, no stale beat emitted, next accepted beat correct.
REQ-043 Carry-in path: a=8'h00, b=8'hFF, cin=1 -> sum=8'h00, cout=1; random 16-bit sweep with WIDTH=16 matches the reference sum.

Source files
------------

// File: rtl/cla8_pipe.sv
// Two-stage pipelined parallel-prefix (Kogge-Stone) adder with valid/ready flow control.
// Optional signed-overflow output is enabled by defining CLA8_PIPE_OVF_EN.
module cla8_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA8_PIPE_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int LEVELS = $clog2(WIDTH);

   // Handshake: a beat moves whenever valid and ready are both high at a rising
   // edge; valid never depends on ready, and outputs stay stable while stalled.
   logic             s1_v;
   logic [WIDTH-1:0] s1_h;
   logic [WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s1_g;
   logic             s1_cin;
   logic             adv2;
   logic             accept;

   assign adv2     = s1_v & (~out_valid | out_ready);
   assign in_ready = ~rst & (~s1_v | adv2);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s1_h   <= '0;
         s1_p   <= '0;
         s1_g   <= '0;
         s1_cin <= 1'b0;
      end else if (accept) begin
         s1_v   <= 1'b1;
         s1_h   <= a ^ b;
         s1_p   <= a | b;
         s1_g   <= a & b;
         s1_cin <= cin;
      end else if (adv2) begin
         s1_v   <= 1'b0;
      end
   end

   // cin is the generate at position -1; merging it into bit 0 up front lets the
   // tree span [i:-1] with only log2(WIDTH) levels.
   logic [WIDTH-1:0] g_seed;
   assign g_seed = {s1_g[WIDTH-1:1], s1_g[0] | (s1_p[0] & s1_cin)};

   genvar k, i;
   generate
      for (k = 0; k < LEVELS; k++) begin : g_lvl
         logic [WIDTH-1:0] g_in;
         logic [WIDTH-1:0] p_in;
         logic [WIDTH-1:0] g_out;
         logic [WIDTH-1:0] p_out;
         if (k == 0) begin : g_first
            assign g_in = g_seed;
            assign p_in = s1_p;
         end else begin : g_next
            assign g_in = g_lvl[k-1].g_out;
            assign p_in = g_lvl[k-1].p_out;
         end
         for (i = 0; i < WIDTH; i++) begin : g_node
            if (i >= (1 << k)) begin : g_op
               assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-(1<<k)]);
               assign p_out[i] = p_in[i] & p_in[i-(1<<k)];
            end else begin : g_pass
               assign g_out[i] = g_in[i];
               assign p_out[i] = p_in[i];
            end
         end
      end
   endgenerate

   // Group propagate of the final level has no consumer.
   logic prefix_p_unused;
   assign prefix_p_unused = ^g_lvl[LEVELS-1].p_out;

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_next;
   assign carry    = {g_lvl[LEVELS-1].g_out, s1_cin};
   assign sum_next = s1_h ^ carry[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else if (adv2) begin
         out_valid <= 1'b1;
         sum       <= sum_next;
         cout      <= carry[WIDTH];
      end else if (out_valid & out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef CLA8_PIPE_OVF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (adv2) begin
         ovf <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_cla8_pipe.sv
// Self-checking bench for cla8_pipe: 8-bit instance with scoreboard, plus a 16-bit sweep instance.
module tb_cla8_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;
`ifdef CLA8_PIPE_OVF_EN
   logic       ovf;
`endif

   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        cin16;
   logic        out_valid16;
   logic        out_ready16;
   logic [15:0] sum16;
   logic        cout16;
`ifdef CLA8_PIPE_OVF_EN
   logic        ovf16;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_out    = 0;

   logic [9:0]  exp_q[$];
   logic [16:0] exp16_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   cla8_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
`ifdef CLA8_PIPE_OVF_EN
      , .ovf(ovf)
`endif
   );

   cla8_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
      .sum(sum16), .cout(cout16)
`ifdef CLA8_PIPE_OVF_EN
      , .ovf(ovf16)
`endif
   );

   // Scoreboard for the 8-bit instance: push on accept, pop on handoff.
   always @(negedge clk) begin : mon
      logic [8:0] t;
      logic       ov;
      logic [9:0] e;
      if (!rst) begin
         if (in_valid && in_ready) begin
            t  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            ov = (a[7] == b[7]) && (t[7] != a[7]);
            exp_q.push_back({ov, t});
         end
         if (out_valid && out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL scoreboard_unexpected got sum=%h cout=%b with nothing expected", sum, cout);
            end else begin
               e = exp_q.pop_front();
               if ({cout, sum} !== e[8:0]) begin
                  failures++;
                  $display("FAIL scoreboard_sum got cout/sum=%h expected=%h", {cout, sum}, e[8:0]);
               end
`ifdef CLA8_PIPE_OVF_EN
               checks++;
               if (ovf !== e[9]) begin
                  failures++;
                  $display("FAIL scoreboard_ovf got=%b expected=%b", ovf, e[9]);
               end
`endif
            end
         end
      end
   end

   task automatic drive_beat(input logic [7:0] va, input logic [7:0] vb, input logic vc);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      in_valid = 1'b1; a = va; b = vb; cin = vc;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++; failures++;
         $display("FAIL drive_timeout in_ready=%b required=1", in_ready);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, cout, sum} !== 11'd0) begin
         failures++;
         $display("FAIL reset_state got rdy/vld/cout/sum=%b/%b/%b/%h required=0/0/0/00",
                  in_ready, out_valid, cout, sum);
      end
`ifdef CLA8_PIPE_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf got=%b required=0", ovf);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b required=1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   // Checks latency N+2, the registered result, and hold after handoff.
   task automatic check_latency(input string name, input logic [7:0] va, input logic [7:0] vb,
                                input logic vc, input logic [7:0] xs, input logic xc);
      drive_beat(va, vb, vc);
      idle();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_early out_valid=%b required=0", name, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sum !== xs || cout !== xc) begin
         failures++;
         $display("FAIL %s_result got vld=%b sum=%h cout=%b required vld=1 sum=%h cout=%b",
                  name, out_valid, sum, cout, xs, xc);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sum !== xs || cout !== xc) begin
         failures++;
         $display("FAIL %s_hold got vld=%b sum=%h cout=%b required vld=0 sum=%h cout=%b",
                  name, out_valid, sum, cout, xs, xc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_carry_ripple();
      check_latency("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_carry_in();
      check_latency("cin", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
   endtask

`ifdef CLA8_PIPE_OVF_EN
   task automatic test_overflow();
      check_latency("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      check_latency("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
   endtask
`endif

   task automatic test_back_to_back();
      int c0, n0;
      c0 = cyc; n0 = n_out;
      for (int k = 0; k < 256; k++)
         drive_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      idle();
      checks++;
      if (cyc - c0 != 256) begin
         failures++;
         $display("FAIL stream_input_rate cycles=%0d required=256", cyc - c0);
      end
      drain("stream");
      checks++;
      if (n_out - n0 != 256) begin
         failures++;
         $display("FAIL stream_count outputs=%0d required=256", n_out - n0);
      end
   endtask

   task automatic test_backpressure();
      int         n_acc;
      logic       acc;
      logic [7:0] held;
      n_acc = 0;
      held = '0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); cin = 1'($urandom_range(0, 1));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) n_acc++;
         if (k == 2) held = sum;
         @(posedge clk); #1;
         if (acc) begin
            a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); cin = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);
      checks++;
      if (n_acc != 2 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_accepts got=%0d in_ready=%b required=2 and 0", n_acc, in_ready);
      end
      checks++;
      if (exp_q.size() == 0 || out_valid !== 1'b1 || sum !== held || {cout, sum} !== exp_q[0][8:0]) begin
         failures++;
         $display("FAIL bp_hold got vld=%b cout/sum=%h held=%h required vld=1 stable first result",
                  out_valid, {cout, sum}, held);
      end
      @(posedge clk); #1;
      idle();
      out_ready = 1'b1;
      drain("bp");
   endtask

   task automatic test_mid_reset();
      logic seen;
      seen = 1'b0;
      out_ready = 1'b0;
      drive_beat(8'h12, 8'h34, 1'b0);
      drive_beat(8'h56, 8'h78, 1'b1);
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_state got vld=%b sum=%h cout=%b rdy=%b required 0/00/0/1",
                  out_valid, sum, cout, in_ready);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL midrst_stale got out_valid=1 required=0");
      end
      @(posedge clk); #1;
      drive_beat(8'hA5, 8'h5A, 1'b1);
      idle();
      drain("midrst");
   endtask

   task automatic test_wide16();
      logic [16:0] t, e;
      int          n_acc;
      n_acc = 0;
      out_ready16 = 1'b1;
      for (int k = 0; k < 68; k++) begin
         in_valid16 = (k < 64);
         a16 = 16'($urandom_range(0, 65535));
         b16 = 16'($urandom_range(0, 65535));
         cin16 = 1'($urandom_range(0, 1));
         if (k == 0) begin a16 = 16'h0000; b16 = 16'hFFFF; cin16 = 1'b1; end
         @(negedge clk);
         if (in_valid16 && in_ready16) begin
            n_acc++;
            t = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
            exp16_q.push_back(t);
         end
         if (out_valid16 && out_ready16) begin
            checks++;
            if (exp16_q.size() == 0) begin
               failures++;
               $display("FAIL wide16_unexpected got sum=%h", sum16);
            end else begin
               e = exp16_q.pop_front();
               if ({cout16, sum16} !== e) begin
                  failures++;
                  $display("FAIL wide16_sum got=%h expected=%h", {cout16, sum16}, e);
               end
            end
         end
         @(posedge clk); #1;
      end
      in_valid16 = 1'b0;
      checks++;
      if (n_acc != 64 || exp16_q.size() != 0) begin
         failures++;
         $display("FAIL wide16_flow accepts=%0d pending=%0d required 64 and 0", n_acc, exp16_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_carry_ripple();
      test_carry_in();
`ifdef CLA8_PIPE_OVF_EN
      test_overflow();
`endif
      test_back_to_back();
      test_backpressure();
      test_mid_reset();
      test_wide16();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL final_queue pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
